core_s1_s2_ibuf: RTL and testbench

Instruction buffer between fetch stage 1 (`core_s1`) and decode stage 2 (`core_s2`). It holds up to `DEPTH` fetched instructions with their PC and fetch-fault flag, and decouples fetch from decode back-pressure using valid/ready handshakes on both sides. A synchronous flush from later stages (branch or trap redirect) discards all buffered and in-flight entries.

---
 rtl/core_s1_s2_ibuf_if.sv | 24 ++
 rtl/core_s1_s2_ibuf.sv | 95 +++++++++
 tb/tb_core_s1_s2_ibuf.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/core_s1_s2_ibuf_if.sv
// Handshake bundle between fetch stage 1 and decode stage 2 through the instruction buffer.
// slave = buffer side, master = the fetch/decode environment driving it.
interface core_s1_s2_ibuf_if;
  logic        s1_valid_i;
  logic        s1_ready_o;
  logic [31:0] s1_pc_i;
  logic [31:0] s1_instr_i;
  logic        s1_fault_i;
  logic        s2_valid_o;
  logic        s2_ready_i;
  logic [31:0] s2_pc_o;
  logic [31:0] s2_instr_o;
  logic        s2_fault_o;

  modport slave (
    input  s1_valid_i, s1_pc_i, s1_instr_i, s1_fault_i, s2_ready_i,
    output s1_ready_o, s2_valid_o, s2_pc_o, s2_instr_o, s2_fault_o
  );

  modport master (
    output s1_valid_i, s1_pc_i, s1_instr_i, s1_fault_i, s2_ready_i,
    input  s1_ready_o, s2_valid_o, s2_pc_o, s2_instr_o, s2_fault_o
  );
endinterface

// File: rtl/core_s1_s2_ibuf.sv
// Circular instruction buffer decoupling fetch (s1) from decode (s2); flush discards everything.
// Optional zero-latency empty bypass enabled by defining LETC_CORE_IBUF_BYPASS_EN.
module core_s1_s2_ibuf #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  core_s1_s2_ibuf_if.slave         bus,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW:0]        count_q, count_d;
  logic               empty, bypass, push, pop;
  entry_t             head;

  assign empty = (count_q == '0);

`ifdef LETC_CORE_IBUF_BYPASS_EN
  assign bypass = empty && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  // Ready never looks at s2_ready_i, so no combinational ready chain crosses the buffer.
  always_comb begin
    head            = mem_q[rd_ptr_q];
    bus.s1_ready_o  = (count_q != FULL) && !flush_i;
    bus.s2_valid_o  = !empty && !flush_i;
    bus.s2_pc_o     = head.pc;
    bus.s2_instr_o  = head.instr;
    bus.s2_fault_o  = head.fault;
    if (bypass) begin
      bus.s2_valid_o = bus.s1_valid_i;
      bus.s2_pc_o    = bus.s1_pc_i;
      bus.s2_instr_o = bus.s1_instr_i;
      bus.s2_fault_o = bus.s1_fault_i;
    end
  end

  // A bypassed instruction taken by decode is never written.
  assign push = bus.s1_valid_i && bus.s1_ready_o && !(bypass && bus.s2_ready_i);
  assign pop  = bus.s2_valid_o && bus.s2_ready_i && !bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + (PW+1)'(1);
      else if (pop && !push) count_d = count_q - (PW+1)'(1);
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = '{pc: bus.s1_pc_i, instr: bus.s1_instr_i, fault: bus.s1_fault_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is qualified by the pointers/count, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count_o = count_q;
endmodule

// File: tb/tb_core_s1_s2_ibuf.sv
// Self-checking bench for core_s1_s2_ibuf: directed scenarios plus random traffic against a queue model.
module tb_core_s1_s2_ibuf;
  localparam int DEPTH = 4;
`ifdef LETC_CORE_IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  logic clk, rst_n, flush;
  logic [$clog2(DEPTH):0] count;
  core_s1_s2_ibuf_if bus ();

  core_s1_s2_ibuf #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .bus     (bus),
    .count_o (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  // One cycle: drive at negedge, check combinational outputs, then advance the model at posedge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic f, input logic rdy, input logic fl);
    ent_t e;
    logic ev, er;
    int   n;
    bus.s1_valid_i = v;
    bus.s1_pc_i    = pc;
    bus.s1_instr_i = ins;
    bus.s1_fault_i = f;
    bus.s2_ready_i = rdy;
    flush          = fl;
    #1;
    n  = q.size();
    er = (n < DEPTH) && !fl;
    ev = !fl && ((n > 0) || (BYP && v));
    chk("s1_ready", 32'(bus.s1_ready_o), 32'(er));
    chk("s2_valid", 32'(bus.s2_valid_o), 32'(ev));
    chk("count",    32'(count),          32'(n));
    if (ev) begin
      if (n > 0) e = q[0];
      else       e = '{pc, ins, f};
      chk("s2_pc",    bus.s2_pc_o,           e.pc);
      chk("s2_instr", bus.s2_instr_o,        e.instr);
      chk("s2_fault", 32'(bus.s2_fault_o),   32'(e.fault));
    end
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (ev && rdy && n > 0) void'(q.pop_front());
      if (v && er && !(n == 0 && ev && rdy)) q.push_back('{pc, ins, f});
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.s1_valid_i = 1'b0;
    bus.s1_pc_i    = '0;
    bus.s1_instr_i = '0;
    bus.s1_fault_i = 1'b0;
    bus.s2_ready_i = 1'b0;

    // Reset held with random payload/ready
    repeat (3) begin
      @(negedge clk);
      bus.s1_pc_i    = $urandom;
      bus.s1_instr_i = $urandom;
      bus.s1_fault_i = 1'($urandom_range(0, 1));
      bus.s2_ready_i = 1'($urandom_range(0, 1));
      #1;
      chk("rst_s1_ready", 32'(bus.s1_ready_o), 32'd1);
      chk("rst_s2_valid", 32'(bus.s2_valid_o), 32'd0);
      chk("rst_count",    32'(count),          32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Fill to full, then drain in order
    for (int k = 0; k < 4; k++) step(1'b1, 32'(4*k), 32'h1000 + 32'(k), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h10, 32'hdead, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Streaming push+pop every cycle across pointer wrap
    for (int k = 0; k < 10; k++) step(1'b1, 32'h100 + 32'(4*k), 32'h2000 + 32'(k), 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Full plus pop: pop happens, push refused
    for (int k = 0; k < 4; k++) step(1'b1, 32'h300 + 32'(4*k), 32'h3000 + 32'(k), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h400, 32'h4000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Flush at count 3 with both handshakes requested
    step(1'b1, 32'h500, 32'h5000, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h200, 32'h6000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h204, 32'h6001, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Fault entry passes through untouched
    step(1'b1, 32'h600, 32'h00000013, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h604, 32'h00000013, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Random traffic with occasional flush
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));

    // Asynchronous reset mid-operation
    for (int k = 0; k < 3; k++) step(1'b1, 32'h700 + 32'(4*k), 32'h7000, 1'b0, 1'b0, 1'b0);
    bus.s1_valid_i = 1'b0;
    bus.s2_ready_i = 1'b0;
    flush          = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count",    32'(count),          32'd0);
    chk("async_rst_s2_valid", 32'(bus.s2_valid_o), 32'd0);
    chk("async_rst_s1_ready", 32'(bus.s1_ready_o), 32'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h800, 32'h8000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
